// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES SPI link scheduler: FSM states, op encoding
// and the bit-counter width sized for the longest (Nk=8) job.
package aes_sched_pkg;

    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned CNT_W     = $clog2(AES_BLK_W + 8 * 32 + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWait,
        StRecv,
        StResp
    } sched_state_e;

    typedef enum logic {
        OpEnc = 1'b0,
        OpDec = 1'b1
    } op_e;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin arbiter between the encrypt and decrypt clients. The priority
// pointer passes to the other client whenever accept_i pulses.
module aes_rr_arbiter (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_enc_i,
    input  logic req_dec_i,
    input  logic accept_i,
    output logic gnt_enc_o,
    output logic gnt_dec_o
);

    // prio_q = 1 means the decrypt client wins a tie.
    logic prio_q, prio_d;

    always_comb begin
        gnt_enc_o = req_enc_i && (!req_dec_i || !prio_q);
        gnt_dec_o = req_dec_i && (!req_enc_i || prio_q);
        prio_d    = prio_q;
        if (accept_i) begin
            prio_d = gnt_enc_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/aes_spi_scheduler.sv
// Sole master of the bit-serial AES SPI link: arbitrates encrypt/decrypt jobs, shifts out
// {data, key}, collects the 128-bit result. Optional WAIT timeout via AES_SCHED_TIMEOUT_EN.
module aes_spi_scheduler
    import aes_sched_pkg::*;
#(
    parameter int unsigned Nk      = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enc_valid,
    output logic                 enc_ready,
    input  logic [127:0]         enc_data,
    input  logic [Nk*32-1:0]     enc_key,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [127:0]         dec_data,
    input  logic [Nk*32-1:0]     dec_key,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [127:0]         resp_data,
    output logic                 resp_is_dec,
    output logic                 resp_err,
    output logic                 cs_enc_n,
    output logic                 cs_dec_n,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 busy
);

    localparam int unsigned ShW = AES_BLK_W + Nk * 32;

    sched_state_e           state_q, state_d;
    logic [ShW-1:0]         sreg_q, sreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    op_e                    op_q, op_d;
    logic [AES_BLK_W-1:0]   rdata_q, rdata_d;
    logic                   gnt_enc, gnt_dec, accept, link_active;

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic                   err_q, err_d;
`else
    logic                   unused_tmo;
    assign unused_tmo = ^32'(TIMEOUT);
`endif

    aes_rr_arbiter u_arb (
        .clk_i     (clk),
        .rst_ni    (rst),
        .req_enc_i (enc_valid),
        .req_dec_i (dec_valid),
        .accept_i  (accept),
        .gnt_enc_o (gnt_enc),
        .gnt_dec_o (gnt_dec)
    );

    assign enc_ready = (state_q == StIdle) && gnt_enc;
    assign dec_ready = (state_q == StIdle) && gnt_dec;
    assign accept    = (enc_valid && enc_ready) || (dec_valid && dec_ready);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rdata_d = rdata_q;
`ifdef AES_SCHED_TIMEOUT_EN
        tmo_d   = '0;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = gnt_dec ? OpDec : OpEnc;
                    sreg_d  = gnt_dec ? {dec_data, dec_key} : {enc_data, enc_key};
                    cnt_d   = '0;
`ifdef AES_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = StSend;
                end
            end
            StSend: begin
                sreg_d = {sreg_q[ShW-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ShW - 1)) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (miso) begin
                    state_d = StRecv;
`ifdef AES_SCHED_TIMEOUT_EN
                end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StResp;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            StRecv: begin
                rdata_d = {rdata_q[AES_BLK_W-2:0], miso};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(AES_BLK_W - 1)) begin
                    cnt_d   = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OpEnc;
            rdata_q <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
`ifdef AES_SCHED_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    // Only the latched client's select may go low, so both are never low together.
    assign link_active = state_q inside {StSend, StWait, StRecv};
    assign cs_enc_n    = !(link_active && (op_q == OpEnc));
    assign cs_dec_n    = !(link_active && (op_q == OpDec));
    assign mosi        = (state_q == StSend) ? sreg_q[ShW-1] : 1'b0;
    assign busy        = (state_q != StIdle);
    assign resp_valid  = (state_q == StResp);
    assign resp_data   = rdata_q;
    assign resp_is_dec = (op_q == OpDec);
`ifdef AES_SCHED_TIMEOUT_EN
    assign resp_err    = err_q;
`else
    assign resp_err    = 1'b0;
`endif

endmodule
